// File: rtl/dot_line_framer.sv
// Serialises one HEAD_WIDTH-bit dot line per handshake into a byte-wide frame: sync, sequence, [dot count], dots.
// Define DOT_LINE_DOT_COUNT_EN to insert a 16-bit popcount (CNT_HI, CNT_LO) between the sequence byte and the dots.
module dot_line_framer #(
    parameter int         HEAD_WIDTH = 384,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [HEAD_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic                  out_last,
    output logic                  busy
);
    localparam int         NUM_BYTES = HEAD_WIDTH / 8;
    localparam logic [15:0] LAST_IDX = 16'(NUM_BYTES - 1);

`ifdef DOT_LINE_DOT_COUNT_EN
    typedef enum logic [2:0] {IDLE, SYNC, SEQ, CNT_HI, CNT_LO, DATA} state_t;
`else
    typedef enum logic [2:0] {IDLE, SYNC, SEQ, DATA} state_t;
`endif

    state_t                  state_reg, state_next;
    logic [HEAD_WIDTH-1:0]   line_reg, line_next;
    logic [7:0]              seq_reg, seq_next;
    logic [15:0]             byte_cnt_reg, byte_cnt_next;
    logic                    out_valid_reg, out_valid_next;
    logic [7:0]              out_data_reg, out_data_next;
    logic                    out_last_reg, out_last_next;
    logic                    advance;
    logic                    load_data;

`ifdef DOT_LINE_DOT_COUNT_EN
    logic [15:0] count_reg, count_next;
    logic [15:0] popcount;

    always_comb begin
        popcount = '0;
        for (int i = 0; i < HEAD_WIDTH; i++) begin
            popcount = popcount + 16'(in_data[i]);
        end
    end
`endif

    assign advance = out_valid_reg && out_ready;

    always_comb begin
        state_next     = state_reg;
        line_next      = line_reg;
        seq_next       = seq_reg;
        byte_cnt_next  = byte_cnt_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_last_next  = out_last_reg;
        load_data      = 1'b0;
`ifdef DOT_LINE_DOT_COUNT_EN
        count_next     = count_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next     = SYNC;
                    line_next      = in_data;
                    out_valid_next = 1'b1;
                    out_data_next  = SYNC_BYTE;
`ifdef DOT_LINE_DOT_COUNT_EN
                    count_next     = popcount;
`endif
                end
            end
            SYNC: begin
                if (advance) begin
                    state_next    = SEQ;
                    out_data_next = seq_reg;
                end
            end
            SEQ: begin
                if (advance) begin
`ifdef DOT_LINE_DOT_COUNT_EN
                    state_next    = CNT_HI;
                    out_data_next = count_reg[15:8];
`else
                    load_data     = 1'b1;
`endif
                end
            end
`ifdef DOT_LINE_DOT_COUNT_EN
            CNT_HI: begin
                if (advance) begin
                    state_next    = CNT_LO;
                    out_data_next = count_reg[7:0];
                end
            end
            CNT_LO: begin
                if (advance) begin
                    load_data = 1'b1;
                end
            end
`endif
            DATA: begin
                if (advance) begin
                    if (byte_cnt_reg == LAST_IDX) begin
                        state_next     = IDLE;
                        out_valid_next = 1'b0;
                        out_last_next  = 1'b0;
                        out_data_next  = 8'h00;
                        seq_next       = seq_reg + 8'd1;
                    end else begin
                        out_data_next  = line_reg[HEAD_WIDTH-1 -: 8];
                        line_next      = line_reg << 8;
                        byte_cnt_next  = byte_cnt_reg + 16'd1;
                        out_last_next  = ((byte_cnt_reg + 16'd1) == LAST_IDX);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // First dot byte comes off the top of the line; the register then shifts up.
        if (load_data) begin
            state_next    = DATA;
            out_data_next = line_reg[HEAD_WIDTH-1 -: 8];
            line_next     = line_reg << 8;
            byte_cnt_next = 16'd0;
            out_last_next = (LAST_IDX == 16'd0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            line_reg      <= '0;
            seq_reg       <= 8'h00;
            byte_cnt_reg  <= 16'd0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= 8'h00;
            out_last_reg  <= 1'b0;
`ifdef DOT_LINE_DOT_COUNT_EN
            count_reg     <= 16'd0;
`endif
        end else begin
            state_reg     <= state_next;
            line_reg      <= line_next;
            seq_reg       <= seq_next;
            byte_cnt_reg  <= byte_cnt_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_last_reg  <= out_last_next;
`ifdef DOT_LINE_DOT_COUNT_EN
            count_reg     <= count_next;
`endif
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
endmodule

// File: tb/tb_dot_line_framer.sv
// Self-checking bench for dot_line_framer: frame-level scoreboard, directed vector table, corner sequences, random traffic.
module tb_dot_line_framer;
    localparam int HW = 384;
    localparam int NB = HW / 8;
`ifdef DOT_LINE_DOT_COUNT_EN
    localparam int HDR = 4;
`else
    localparam int HDR = 2;
`endif
    localparam int FLEN = HDR + NB;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [HW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic          out_last;
    logic          busy;

    always #5 clk = ~clk;

    dot_line_framer #(.HEAD_WIDTH(HW), .SYNC_BYTE(8'hA5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    typedef struct {
        logic [HW-1:0] line;
        logic [7:0]    exp_b2;
        logic [7:0]    exp_b3;
        logic [7:0]    exp_tail;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [7:0]  exp_q[$];
    bit          exp_last_q[$];
    logic [7:0]  cur_frame[$];
    logic [7:0]  done_frame[$];
    int          frames_done = 0;
    int          model_seq = 0;
    bit          captured_now;
    int          last_byte_cyc = -10;
    int          cap_cyc = -20;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data;
    logic        prev_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference frame: sync, sequence, optional 16-bit dot count, then the line MSB byte first.
    task automatic build_frame(input logic [HW-1:0] line);
        logic [15:0] cnt;
        exp_q.push_back(8'hA5);            exp_last_q.push_back(1'b0);
        exp_q.push_back(8'(model_seq));    exp_last_q.push_back(1'b0);
`ifdef DOT_LINE_DOT_COUNT_EN
        cnt = 16'($countones(line));
        exp_q.push_back(cnt[15:8]);        exp_last_q.push_back(1'b0);
        exp_q.push_back(cnt[7:0]);         exp_last_q.push_back(1'b0);
`else
        cnt = 16'd0;
`endif
        for (int i = 0; i < NB; i++) begin
            exp_q.push_back(line[HW-1-8*i -: 8]);
            exp_last_q.push_back(i == NB - 1);
        end
        model_seq = (model_seq + 1) % 256;
    endtask

    // One clock: check the current (negedge) view, account for handshakes at the coming edge, advance.
    task automatic tick();
        logic [7:0] e;
        bit         l;
        captured_now = 1'b0;
        if (reset) begin
            chk("ctl", 32'({in_ready, out_valid, busy}),
                32'({exp_q.size() == 0, exp_q.size() != 0, exp_q.size() != 0}));
            if (prev_stall)
                chk("hold", 32'({out_valid, out_last, out_data}), 32'({1'b1, prev_last, prev_data}));
            if (out_valid && out_ready) begin
                chk("q_nonempty", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    l = exp_last_q.pop_front();
                    chk("byte", 32'({out_last, out_data}), 32'({l, e}));
                end
                cur_frame.push_back(out_data);
                if (out_last) begin
                    done_frame = cur_frame;
                    cur_frame.delete();
                    frames_done++;
                    last_byte_cyc = cyc;
                end
            end
            if (in_valid && in_ready) begin
                build_frame(in_data);
                captured_now = 1'b1;
                cap_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outs", 32'({out_valid, out_last, out_data, in_ready, busy}),
            32'({1'b0, 1'b0, 8'h00, 1'b1, 1'b0}));
        exp_q.delete();
        exp_last_q.delete();
        cur_frame.delete();
        done_frame.delete();
        model_seq  = 0;
        prev_stall = 1'b0;
        reset      = 1'b1;
    endtask

    task automatic send(input logic [HW-1:0] line);
        int n = 0;
        in_data  = line;
        in_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!captured_now && n < 2000);
        chk("capture", 32'(captured_now), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 5000) begin
            tick();
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic rand_line(output logic [HW-1:0] line);
        for (int j = 0; j < HW / 32; j++) line[j*32 +: 32] = $urandom;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[5];
        logic [HW-1:0] line, line_b;
        int            lows, n;

        vecs[0].line = '0;
        vecs[0].line[HW-1] = 1'b1;
        vecs[0].line[0] = 1'b1;
        vecs[1].line = '1;
        vecs[2].line = '0;
        vecs[3].line = {48{8'h0F}};
        vecs[4].line = {24{16'h8001}};
`ifdef DOT_LINE_DOT_COUNT_EN
        vecs[0].exp_b2 = 8'h00; vecs[0].exp_b3 = 8'h02;
        vecs[1].exp_b2 = 8'h01; vecs[1].exp_b3 = 8'h80;
        vecs[2].exp_b2 = 8'h00; vecs[2].exp_b3 = 8'h00;
        vecs[3].exp_b2 = 8'h00; vecs[3].exp_b3 = 8'hC0;
        vecs[4].exp_b2 = 8'h00; vecs[4].exp_b3 = 8'h30;
`else
        vecs[0].exp_b2 = 8'h80; vecs[0].exp_b3 = 8'h00;
        vecs[1].exp_b2 = 8'hFF; vecs[1].exp_b3 = 8'hFF;
        vecs[2].exp_b2 = 8'h00; vecs[2].exp_b3 = 8'h00;
        vecs[3].exp_b2 = 8'h0F; vecs[3].exp_b3 = 8'h0F;
        vecs[4].exp_b2 = 8'h80; vecs[4].exp_b3 = 8'h01;
`endif
        vecs[0].exp_tail = 8'h01;
        vecs[1].exp_tail = 8'hFF;
        vecs[2].exp_tail = 8'h00;
        vecs[3].exp_tail = 8'h0F;
        vecs[4].exp_tail = 8'h01;

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        @(negedge clk);

        // MSB+LSB line at full rate
        do_reset();
        out_ready = 1'b1;
        send(vecs[0].line);
        lows = 0;
        while (!in_ready && lows < 1000) begin
            tick();
            lows++;
        end
        $display("t1: in_ready low for %0d cycles, frame len %0d", lows, done_frame.size());
        chk("ready_low", 32'(lows), 32'(FLEN));
        chk("t1_len", 32'(done_frame.size()), 32'(FLEN));
        if (done_frame.size() == FLEN) begin
            chk("t1_sync", 32'(done_frame[0]), 32'h A5);
            chk("t1_seq", 32'(done_frame[1]), 32'h00);
            chk("t1_first_dot", 32'(done_frame[HDR]), 32'h80);
            chk("t1_tail", 32'(done_frame[FLEN-1]), 32'h01);
        end

        // table of directed lines
        do_reset();
        for (int v = 0; v < 5; v++) begin
            send(vecs[v].line);
            drain();
            $display("vec %0d: len=%0d", v, done_frame.size());
            chk("vec_len", 32'(done_frame.size()), 32'(FLEN));
            if (done_frame.size() == FLEN) begin
                chk("vec_b2", 32'(done_frame[2]), 32'(vecs[v].exp_b2));
                chk("vec_b3", 32'(done_frame[3]), 32'(vecs[v].exp_b3));
                chk("vec_tail", 32'(done_frame[FLEN-1]), 32'(vecs[v].exp_tail));
            end
        end

        // 257 zero lines: sequence wraps 255 -> 0
        do_reset();
        for (int i = 0; i < 257; i++) begin
            send('0);
            drain();
            $display("seq frame %0d: seq=%02h len=%0d", i, done_frame.size() > 1 ? done_frame[1] : 8'hXX, done_frame.size());
            chk("seq_len", 32'(done_frame.size()), 32'(FLEN));
            if (done_frame.size() > 1) chk("seq", 32'(done_frame[1]), 32'(i % 256));
        end

        // out_ready toggling every cycle
        do_reset();
        out_ready = 1'b1;
        send({12{32'hDEADBEEF}});
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            out_ready = n[0];
            tick();
            n++;
        end
        drain();
        $display("toggle: len=%0d", done_frame.size());
        chk("toggle_len", 32'(done_frame.size()), 32'(FLEN));

        // line B waiting during frame A
        do_reset();
        out_ready = 1'b1;
        send({12{32'h12345678}});
        line_b = {12{32'hCAFEF00D}};
        in_data = line_b;
        in_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!captured_now && n < 1000);
        in_valid = 1'b0;
        $display("back-to-back: A last at %0d, B captured at %0d", last_byte_cyc, cap_cyc);
        chk("b_capture_cycle", 32'(cap_cyc), 32'(last_byte_cyc + 1));
        drain();
        if (done_frame.size() > 1) chk("b_seq", 32'(done_frame[1]), 32'h01);

        // reset while presenting data byte 20
        do_reset();
        out_ready = 1'b1;
        send('1);
        n = 0;
        while (cur_frame.size() < HDR + 20 && n < 1000) begin
            tick();
            n++;
        end
        chk("reach_byte20", 32'(cur_frame.size()), 32'(HDR + 20));
        reset = 1'b0;
        #1;
        $display("mid-frame reset: out_valid=%0b in_ready=%0b busy=%0b", out_valid, in_ready, busy);
        chk("rst_mid", 32'({out_valid, out_last, out_data, in_ready, busy}),
            32'({1'b0, 1'b0, 8'h00, 1'b1, 1'b0}));
        @(negedge clk);
        do_reset();
        send('0);
        drain();
        if (done_frame.size() > 1) chk("post_rst_seq", 32'(done_frame[1]), 32'h00);
        chk("post_rst_len", 32'(done_frame.size()), 32'(FLEN));

        // random traffic against the scoreboard
        do_reset();
        rand_line(line);
        in_data = line;
        for (int k = 0; k < 4000; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid) in_valid = $urandom_range(0, 1) != 0;
            tick();
            if (captured_now) begin
                in_valid = 1'b0;
                rand_line(line);
                in_data = line;
            end
        end
        in_valid = 1'b0;
        drain();
        $display("random: %0d frames completed in total", frames_done);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
